// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding and constants for the data-memory responder
package mips_mem_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_RESP = 2'd2;
    localparam logic [31:0] DATA_SEG_BASE = 32'h10010000;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response valid-ready bus between core and data memory
interface data_mem_responder_if #(parameter int DW = 32);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word RAM with byte write enables and registered read
module data_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en && we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (en && !we) rdata_q <= mem_q[addr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder with wait states over the data segment
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = DATA_SEG_BASE,
    parameter int          WAIT_STATES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic                  busy_o
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  err_q, err_d;
    logic [31:0]           offset;
    logic                  bad, accept, access;
    logic [31:0]           ram_rdata;
    // Errors also pass through WAIT (counter 0) so they answer one edge after acceptance.
    always_comb begin
        offset  = bus.req_addr - BASE_ADDR;
        bad     = (offset >= 32'(MEMORY_DEPTH) * 32'd4) || (bus.req_addr[1:0] != 2'b00);
        accept  = bus.req_valid && state_q == S_IDLE;
        access  = state_q == S_WAIT && cnt_q == 4'd0 && !err_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        if (accept) begin
            write_d = bus.req_write;
            idx_d   = offset[AW+1:2];
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
            err_d   = bad;
            cnt_d   = bad ? 4'd0 : 4'(WAIT_STATES);
            state_d = S_WAIT;
        end else if (state_q == S_WAIT) begin
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
        end else if (state_q == S_RESP && bus.rsp_ready) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end
    data_mem_array #(.DEPTH(MEMORY_DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (write_q),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );
    // The RAM read register holds its word until the next access, so gating it is enough.
    assign bus.req_ready = state_q == S_IDLE;
    assign bus.rsp_valid = state_q == S_RESP;
    assign bus.rsp_error = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = (bus.rsp_valid && !err_q && !write_q) ? ram_rdata : '0;
    assign busy_o        = state_q != S_IDLE;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (WAIT_STATES=1)
module tb_data_mem_responder;
    import mips_mem_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [31:0] rd;
    logic        er;
    always #5 clk = ~clk;
    data_mem_responder_if bus ();
    data_mem_responder #(
        .DATA_WIDTH(32), .MEMORY_DEPTH(256), .BASE_ADDR(DATA_SEG_BASE), .WAIT_STATES(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .busy_o(busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask
    // Entered and left at a falling edge; lat counts falling edges from acceptance to rsp_valid.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input int exp_lat);
        chkb("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = ~d;
        bus.req_be    = ~b;
        chkb("busy_after_accept", busy, 1'b1);
        chkb("ready_low_after_accept", bus.req_ready, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chkb("rsp_valid", bus.rsp_valid, 1'b1);
        chk("latency", lat, exp_lat);
        rd = bus.rsp_rdata;
        er = bus.rsp_error;
    endtask
    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chkb("rsp_done", bus.rsp_valid, 1'b0);
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        issue(1'b1, a, d, b, 3);
        chk("store_rdata", rd, 32'h0);
        chkb("store_err", er, 1'b0);
        finish_rsp();
    endtask
    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, a, 32'h5555_5555, 4'b0000, 3);
        chk("load_rdata", rd, exp);
        chkb("load_err", er, 1'b0);
        finish_rsp();
    endtask
    task automatic bad_req(input logic w, input logic [31:0] a);
        issue(w, a, 32'hFFFF_FFFF, BE_WORD, 2);
        chkb("bad_err", er, 1'b1);
        chk("bad_rdata", rd, 32'h0);
        finish_rsp();
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_be    = 4'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chkb("rst_req_ready", bus.req_ready, 1'b1);
        chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chkb("rst_rsp_error", bus.rsp_error, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        // store then load, byte-enable merge, empty byte mask
        store(32'h1001_0004, 32'hDEAD_BEEF, BE_WORD);
        load(32'h1001_0004, 32'hDEAD_BEEF);
        store(32'h1001_0004, 32'h0000_00AA, 4'b0001);
        load(32'h1001_0004, 32'hDEAD_BEAA);
        store(32'h1001_0004, 32'h1234_5678, 4'b0000);
        load(32'h1001_0004, 32'hDEAD_BEAA);
        store(32'h1001_0004, 32'h0077_0000, 4'b0100);
        load(32'h1001_0004, 32'hDE77_BEAA);
        store(32'h1001_0004, 32'hDEAD_BEAA, BE_WORD);
        // window edges and errors; offsets 0x400 and 0x2 would alias word 0 if not blocked
        store(32'h1001_0000, 32'h1111_1111, BE_WORD);
        store(32'h1001_03FC, 32'h3FC0_3FC0, BE_WORD);
        load(32'h1001_03FC, 32'h3FC0_3FC0);
        bad_req(1'b0, 32'h1001_0400);
        bad_req(1'b0, 32'h1001_0002);
        bad_req(1'b1, 32'h1001_0400);
        bad_req(1'b1, 32'h1001_0002);
        bad_req(1'b0, 32'h1000_FFFC);
        load(32'h1001_0000, 32'h1111_1111);
        load(32'h1001_0004, 32'hDEAD_BEAA);
        // stall with rsp_ready low and a competing store on the bus
        store(32'h1001_0008, 32'h1234_5678, BE_WORD);
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h1001_0004, 32'h0, BE_WORD, 3);
        chk("stall_first_rdata", rd, 32'hDEAD_BEAA);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 32'h1001_0004;
            bus.req_wdata = 32'h0;
            bus.req_be    = BE_WORD;
            @(negedge clk);
            chkb("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_rdata", bus.rsp_rdata, 32'hDEAD_BEAA);
            chkb("stall_error", bus.rsp_error, 1'b0);
            chkb("stall_req_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        finish_rsp();
        chkb("stall_idle_busy", busy, 1'b0);
        load(32'h1001_0004, 32'hDEAD_BEAA);
        // reset while a store sits in WAIT
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h1001_0008;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_be    = BE_WORD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chkb("pre_reset_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chkb("mid_rst_req_ready", bus.req_ready, 1'b1);
        chkb("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chkb("mid_rst_rsp_error", bus.rsp_error, 1'b0);
        chkb("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load(32'h1001_0008, 32'h1234_5678);
        // back-to-back loads, each issued the falling edge after the previous completes
        for (int i = 0; i < 8; i++)
            store(32'h1001_0020 + 32'(4 * i), 32'hA500_0000 + 32'(i) * 32'h0001_0101, BE_WORD);
        for (int i = 0; i < 8; i++)
            load(32'h1001_0020 + 32'(4 * i), 32'hA500_0000 + 32'(i) * 32'h0001_0101);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
